// File: rtl/multicycle_controller.sv
// -----------------------------------------------------------------------------
// multicycle_controller
//
// Control FSM for a multicycle RV32I datapath. It decodes the latched
// instruction fields and steps each instruction through fetch, decode,
// execute, memory and writeback. It is the only source of datapath write
// enables and mux selects. It also produces the 3-bit ALU control, and it
// uses the ALU zero flag to decide branches.
//
// Ports
//   clk         in   system clock, rising edge
//   reset       in   synchronous, active-high; forces FETCH and gates enables
//   op          in   instr[6:0]
//   funct3      in   instr[14:12]
//   funct7b5    in   instr[30]
//   zero        in   ALU result == 0 (looked at only in BRANCH)
//   pcwrite     out  PC register enable
//   adrsrc      out  memory address select: 0 PC, 1 ALUOut
//   memwrite    out  data memory write strobe
//   irwrite     out  instruction/oldPC register enable
//   resultsrc   out  00 ALUOut, 01 Data, 10 ALU result
//   alusrca     out  00 PC, 01 oldPC, 10 rd1
//   alusrcb     out  00 rd2, 01 immext, 10 constant 4
//   immsrc      out  00 I, 01 S, 10 B, 11 J (combinational from op)
//   alucontrol  out  000 add, 001 sub, 010 and, 011 or,
//                    100 xor, 101 slt, 110 sll, 111 srl
//   regwrite    out  register file write enable
//   illegal     out  one-cycle pulse on an unsupported opcode
//   state       out  current state, for debug and verification
// -----------------------------------------------------------------------------
module multicycle_controller (
   input  logic       clk,
   input  logic       reset,
   input  logic [6:0] op,
   input  logic [2:0] funct3,
   input  logic       funct7b5,
   input  logic       zero,
   output logic       pcwrite,
   output logic       adrsrc,
   output logic       memwrite,
   output logic       irwrite,
   output logic [1:0] resultsrc,
   output logic [1:0] alusrca,
   output logic [1:0] alusrcb,
   output logic [1:0] immsrc,
   output logic [2:0] alucontrol,
   output logic       regwrite,
   output logic       illegal,
   output logic [3:0] state
);

   localparam logic [3:0] S_FETCH    = 4'd0;
   localparam logic [3:0] S_DECODE   = 4'd1;
   localparam logic [3:0] S_MEMADR   = 4'd2;
   localparam logic [3:0] S_MEMREAD  = 4'd3;
   localparam logic [3:0] S_MEMWB    = 4'd4;
   localparam logic [3:0] S_MEMWRITE = 4'd5;
   localparam logic [3:0] S_EXECUTER = 4'd6;
   localparam logic [3:0] S_EXECUTEI = 4'd7;
   localparam logic [3:0] S_ALUWB    = 4'd8;
   localparam logic [3:0] S_BRANCH   = 4'd9;
   localparam logic [3:0] S_JAL      = 4'd10;
   localparam logic [3:0] S_TRAP     = 4'd11;

   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_RTYPE  = 7'b0110011;
   localparam logic [6:0] OP_ITYPE  = 7'b0010011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;

   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_SUB   = 2'b01;
   localparam logic [1:0] ALUOP_FUNCT = 2'b10;

   logic [3:0] state_q, state_d;

   // Raw Moore decodes. Enables are gated by reset further down.
   logic       pcupdate;
   logic       branch;
   logic       taken;
   logic [1:0] aluop;
   logic       irwrite_raw;
   logic       memwrite_raw;
   logic       regwrite_raw;
   logic       illegal_raw;

   // ---------------------------------------------------------------------------
   // State register
   // ---------------------------------------------------------------------------
   // NOTE: state is updated with non-blocking assignments, so every process
   // that samples it at this edge sees the value from before the edge.
   always_ff @(posedge clk) begin
      if (reset) state_q <= S_FETCH;
      else       state_q <= state_d;
   end

   assign state = state_q;

   // ---------------------------------------------------------------------------
   // Next-state logic. Terminal states and unused encodings all go to FETCH.
   // ---------------------------------------------------------------------------
   // NOTE: state_d gets its default before the case, so no path can leave it
   // unassigned. That is what keeps this combinational block from becoming a latch.
   always_comb begin
      state_d = S_FETCH;
      case (state_q)
         S_FETCH:  state_d = S_DECODE;
         S_DECODE: begin
            case (op)
               OP_LOAD, OP_STORE: state_d = S_MEMADR;
               OP_RTYPE:          state_d = S_EXECUTER;
               OP_ITYPE:          state_d = S_EXECUTEI;
               OP_BRANCH:         state_d = S_BRANCH;
               OP_JAL:            state_d = S_JAL;
               default:           state_d = S_TRAP;
            endcase
         end
         S_MEMADR:   state_d = op[5] ? S_MEMWRITE : S_MEMREAD;
         S_MEMREAD:  state_d = S_MEMWB;
         S_EXECUTER: state_d = S_ALUWB;
         S_EXECUTEI: state_d = S_ALUWB;
         S_JAL:      state_d = S_ALUWB;
         default:    state_d = S_FETCH;
      endcase
   end

   // ---------------------------------------------------------------------------
   // Moore output decode. Every select is driven to a defined value in every
   // state, including don't-care states.
   // ---------------------------------------------------------------------------
   always_comb begin
      pcupdate     = 1'b0;
      branch       = 1'b0;
      aluop        = ALUOP_ADD;
      adrsrc       = 1'b0;
      irwrite_raw  = 1'b0;
      memwrite_raw = 1'b0;
      regwrite_raw = 1'b0;
      illegal_raw  = 1'b0;
      resultsrc    = 2'b00;
      alusrca      = 2'b00;
      alusrcb      = 2'b00;
      case (state_q)
         S_FETCH: begin
            irwrite_raw = 1'b1;
            alusrcb     = 2'b10;
            resultsrc   = 2'b10;
            pcupdate    = 1'b1;
         end
         S_DECODE: begin
            // Branch/jump target is computed here and parked in ALUOut.
            alusrca = 2'b01;
            alusrcb = 2'b01;
         end
         S_MEMADR: begin
            alusrca = 2'b10;
            alusrcb = 2'b01;
         end
         S_MEMREAD: adrsrc = 1'b1;
         S_MEMWB: begin
            resultsrc    = 2'b01;
            regwrite_raw = 1'b1;
         end
         S_MEMWRITE: begin
            adrsrc       = 1'b1;
            memwrite_raw = 1'b1;
         end
         S_EXECUTER: begin
            alusrca = 2'b10;
            aluop   = ALUOP_FUNCT;
         end
         S_EXECUTEI: begin
            alusrca = 2'b10;
            alusrcb = 2'b01;
            aluop   = ALUOP_FUNCT;
         end
         S_ALUWB: regwrite_raw = 1'b1;
         S_BRANCH: begin
            alusrca = 2'b10;
            aluop   = ALUOP_SUB;
            branch  = 1'b1;
         end
         S_JAL: begin
            // Writes PC to the target taken from ALUOut, while the ALU makes
            // oldPC+4 for the link write in ALUWB.
            alusrca  = 2'b01;
            alusrcb  = 2'b10;
            pcupdate = 1'b1;
         end
         S_TRAP:  illegal_raw = 1'b1;
         default: ;
      endcase
   end

   // Branch condition: only beq/bne are supported. Other funct3 never take.
   always_comb begin
      case (funct3)
         3'b000:  taken = zero;
         3'b001:  taken = ~zero;
         default: taken = 1'b0;
      endcase
   end

   // Reset masks every enable at once, so an aborted instruction cannot
   // commit a write in the cycle reset is seen.
   assign pcwrite  = ~reset & (pcupdate | (branch & taken));
   assign irwrite  = ~reset & irwrite_raw;
   assign memwrite = ~reset & memwrite_raw;
   assign regwrite = ~reset & regwrite_raw;
   assign illegal  = ~reset & illegal_raw;

   // ---------------------------------------------------------------------------
   // Immediate format select, from the opcode only.
   // ---------------------------------------------------------------------------
   always_comb begin
      case (op)
         OP_STORE:  immsrc = 2'b01;
         OP_BRANCH: immsrc = 2'b10;
         OP_JAL:    immsrc = 2'b11;
         default:   immsrc = 2'b00;
      endcase
   end

   // ---------------------------------------------------------------------------
   // ALU control. sra/srai fall back to srl. Only the register form with
   // funct7b5 set turns funct3 000 into sub, so addi with imm[10]=1 still adds.
   // ---------------------------------------------------------------------------
   always_comb begin
      alucontrol = 3'b000;
      case (aluop)
         ALUOP_SUB:   alucontrol = 3'b001;
         ALUOP_FUNCT: begin
            case (funct3)
               3'b000:  alucontrol = (op == OP_RTYPE && funct7b5) ? 3'b001 : 3'b000;
               3'b001:  alucontrol = 3'b110;
               3'b010:  alucontrol = 3'b101;
               3'b100:  alucontrol = 3'b100;
               3'b101:  alucontrol = 3'b111;
               3'b110:  alucontrol = 3'b011;
               3'b111:  alucontrol = 3'b010;
               default: alucontrol = 3'b000;
            endcase
         end
         default:     alucontrol = 3'b000;
      endcase
   end

endmodule

// File: tb/tb_multicycle_controller.sv
// -----------------------------------------------------------------------------
// tb_multicycle_controller
//
// Self-checking bench for multicycle_controller. Each instruction is expanded
// into its list of phases. Every cycle is then compared with the outputs that
// the instruction-level reference model expects for that phase.
// -----------------------------------------------------------------------------
module tb_multicycle_controller;

   // Observable state codes of the controller's phases.
   typedef enum logic [3:0] {
      P_FETCH = 4'd0, P_DECODE = 4'd1, P_MEMADR = 4'd2, P_MEMREAD = 4'd3,
      P_MEMWB = 4'd4, P_MEMWRITE = 4'd5, P_EXECUTER = 4'd6, P_EXECUTEI = 4'd7,
      P_ALUWB = 4'd8, P_BRANCH = 4'd9, P_JAL = 4'd10, P_TRAP = 4'd11
   } phase_e;

   typedef struct packed {
      logic [3:0] st;
      logic       pcwrite;
      logic       adrsrc;
      logic       memwrite;
      logic       irwrite;
      logic [1:0] resultsrc;
      logic [1:0] alusrca;
      logic [1:0] alusrcb;
      logic [1:0] immsrc;
      logic [2:0] alucontrol;
      logic       regwrite;
      logic       illegal;
   } obs_t;

   localparam logic [6:0] LW  = 7'b0000011;
   localparam logic [6:0] SW  = 7'b0100011;
   localparam logic [6:0] RT  = 7'b0110011;
   localparam logic [6:0] IT  = 7'b0010011;
   localparam logic [6:0] BR  = 7'b1100011;
   localparam logic [6:0] JL  = 7'b1101111;

   logic       clk;
   logic       reset;
   logic [6:0] op;
   logic [2:0] funct3;
   logic       funct7b5;
   logic       zero;
   logic       pcwrite, adrsrc, memwrite, irwrite, regwrite, illegal;
   logic [1:0] resultsrc, alusrca, alusrcb, immsrc;
   logic [2:0] alucontrol;
   logic [3:0] state;

   int   errors = 0;
   int   checks = 0;
   obs_t trace[$];

   multicycle_controller dut (
      .clk        (clk),
      .reset      (reset),
      .op         (op),
      .funct3     (funct3),
      .funct7b5   (funct7b5),
      .zero       (zero),
      .pcwrite    (pcwrite),
      .adrsrc     (adrsrc),
      .memwrite   (memwrite),
      .irwrite    (irwrite),
      .resultsrc  (resultsrc),
      .alusrca    (alusrca),
      .alusrcb    (alusrcb),
      .immsrc     (immsrc),
      .alucontrol (alucontrol),
      .regwrite   (regwrite),
      .illegal    (illegal),
      .state      (state)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic obs_t sample();
      obs_t o;
      o.st = state; o.pcwrite = pcwrite; o.adrsrc = adrsrc; o.memwrite = memwrite;
      o.irwrite = irwrite; o.resultsrc = resultsrc; o.alusrca = alusrca;
      o.alusrcb = alusrcb; o.immsrc = immsrc; o.alucontrol = alucontrol;
      o.regwrite = regwrite; o.illegal = illegal;
      return o;
   endfunction

   // ALU operation the instruction asks for, from its funct fields.
   function automatic logic [2:0] arith_op(logic [6:0] o, logic [2:0] f3, logic f7);
      case (f3)
         3'd0:    return (o == RT && f7) ? 3'b001 : 3'b000; // sub / add
         3'd1:    return 3'b110;                            // sll
         3'd2:    return 3'b101;                            // slt
         3'd4:    return 3'b100;                            // xor
         3'd5:    return 3'b111;                            // srl (sra too)
         3'd6:    return 3'b011;                            // or
         3'd7:    return 3'b010;                            // and
         default: return 3'b000;
      endcase
   endfunction

   // Reference outputs for one phase of an instruction.
   function automatic obs_t model(phase_e ph, logic [6:0] o, logic [2:0] f3,
                                  logic f7, logic z, logic rst);
      obs_t e = '0;
      e.st = ph;
      e.immsrc = (o == SW) ? 2'b01 : (o == BR) ? 2'b10 : (o == JL) ? 2'b11 : 2'b00;
      case (ph)
         P_FETCH:    begin e.irwrite = 1; e.alusrcb = 2; e.resultsrc = 2; e.pcwrite = 1; end
         P_DECODE:   begin e.alusrca = 1; e.alusrcb = 1; end
         P_MEMADR:   begin e.alusrca = 2; e.alusrcb = 1; end
         P_MEMREAD:  e.adrsrc = 1;
         P_MEMWB:    begin e.resultsrc = 1; e.regwrite = 1; end
         P_MEMWRITE: begin e.adrsrc = 1; e.memwrite = 1; end
         P_EXECUTER: begin e.alusrca = 2; e.alucontrol = arith_op(o, f3, f7); end
         P_EXECUTEI: begin e.alusrca = 2; e.alusrcb = 1; e.alucontrol = arith_op(o, f3, f7); end
         P_ALUWB:    e.regwrite = 1;
         P_BRANCH:   begin
            e.alusrca = 2; e.alucontrol = 3'b001;
            e.pcwrite = (f3 == 3'd0) ? z : (f3 == 3'd1) ? ~z : 1'b0;
         end
         P_JAL:      begin e.alusrca = 1; e.alusrcb = 2; e.pcwrite = 1; end
         P_TRAP:     e.illegal = 1;
         default:    ;
      endcase
      if (rst) begin
         e.pcwrite = 0; e.memwrite = 0; e.irwrite = 0; e.regwrite = 0; e.illegal = 0;
      end
      return e;
   endfunction

   // Runs one instruction from FETCH, comparing every cycle with the model.
   // zero_mode 0/1 holds zero at that value; 2 randomises it per cycle.
   // abort_at >= 0 raises reset during that phase and stops the instruction.
   // Entry/exit point: just after a falling edge.
   task automatic run_instr(input string name, input logic [6:0] op_v,
                            input logic [2:0] f3_v, input logic f7_v,
                            input int zero_mode, input int abort_at);
      phase_e plan[$];
      obs_t   got, want;
      logic   z;
      plan = {P_FETCH, P_DECODE};
      case (op_v)
         LW:      plan = {plan, P_MEMADR, P_MEMREAD, P_MEMWB};
         SW:      plan = {plan, P_MEMADR, P_MEMWRITE};
         RT:      plan = {plan, P_EXECUTER, P_ALUWB};
         IT:      plan = {plan, P_EXECUTEI, P_ALUWB};
         BR:      plan = {plan, P_BRANCH};
         JL:      plan = {plan, P_JAL, P_ALUWB};
         default: plan = {plan, P_TRAP};
      endcase
      trace = {};
      for (int k = 0; k < plan.size(); k++) begin
         z = (zero_mode == 2) ? 1'($urandom_range(0, 1)) : 1'(zero_mode);
         op = op_v; funct3 = f3_v; funct7b5 = f7_v; zero = z;
         reset = (k == abort_at);
         #1;
         got  = sample();
         want = model(plan[k], op_v, f3_v, f7_v, z, reset);
         trace.push_back(got);
         checks++;
         if (got !== want) begin
            errors++;
            $display("FAIL %s op=%b f3=%0d cycle %0d: got %h expected %h",
                     name, op_v, f3_v, k, got, want);
         end
         @(negedge clk);
         if (k == abort_at) begin
            reset = 1'b0;
            break;
         end
      end
   endtask

   task automatic test_reset();
      obs_t got, want;
      reset = 1'b1; op = '0; funct3 = '0; funct7b5 = 1'b0; zero = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      got  = sample();
      want = model(P_FETCH, 7'b0, 3'b0, 1'b0, 1'b0, 1'b1);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL reset_hold: got %h expected %h", got, want);
      end
      reset = 1'b0;
   endtask

   task automatic test_lw();
      logic [4:0] rw_mask, pc_mask;
      run_instr("lw", LW, 3'(2), 1'b0, 2, -1);
      rw_mask = '0; pc_mask = '0;
      foreach (trace[i]) begin
         rw_mask[i] = trace[i].regwrite;
         pc_mask[i] = trace[i].pcwrite;
      end
      checks++;
      if (rw_mask !== 5'b10000 || pc_mask !== 5'b00001) begin
         errors++;
         $display("FAIL lw_enables: regwrite %b pcwrite %b expected 10000 00001", rw_mask, pc_mask);
      end
   endtask

   task automatic test_sw();
      int mw = 0, rw = 0;
      run_instr("sw", SW, 3'(2), 1'b0, 2, -1);
      foreach (trace[i]) begin
         mw += int'(trace[i].memwrite);
         rw += int'(trace[i].regwrite);
      end
      checks++;
      if (mw != 1 || rw != 0 || trace[3].memwrite !== 1'b1 || trace[3].adrsrc !== 1'b1) begin
         errors++;
         $display("FAIL sw_strobe: memwrite cycles %0d regwrite cycles %0d adrsrc %b expected 1 0 1",
                  mw, rw, trace[3].adrsrc);
      end
   endtask

   task automatic test_alu_decode();
      logic [6:0] t_op[6]  = '{RT, IT, RT, RT, RT, IT};
      logic [2:0] t_f3[6]  = '{3'd0, 3'd0, 3'd5, 3'd5, 3'd1, 3'd7};
      logic       t_f7[6]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
      logic [2:0] t_exp[6] = '{3'b001, 3'b000, 3'b111, 3'b111, 3'b110, 3'b010};
      for (int i = 0; i < 6; i++) begin
         run_instr("alu", t_op[i], t_f3[i], t_f7[i], 2, -1);
         checks++;
         if (trace[2].alucontrol !== t_exp[i]) begin
            errors++;
            $display("FAIL alu_decode[%0d]: alucontrol %b expected %b", i, trace[2].alucontrol, t_exp[i]);
         end
      end
   endtask

   task automatic test_branch();
      logic [2:0] t_f3[6]  = '{3'd0, 3'd0, 3'd1, 3'd1, 3'd4, 3'd4};
      int         t_z[6]   = '{1, 0, 1, 0, 1, 0};
      logic       t_pc[6]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
      for (int i = 0; i < 6; i++) begin
         run_instr("branch", BR, t_f3[i], 1'b0, t_z[i], -1);
         checks++;
         if (trace[2].pcwrite !== t_pc[i] || trace[2].alucontrol !== 3'b001) begin
            errors++;
            $display("FAIL branch[%0d]: pcwrite %b alucontrol %b expected %b 001",
                     i, trace[2].pcwrite, trace[2].alucontrol, t_pc[i]);
         end
      end
   endtask

   task automatic test_jal();
      run_instr("jal", JL, 3'($urandom_range(0, 7)), 1'b0, 2, -1);
      checks++;
      if (trace[2].pcwrite !== 1'b1 || trace[2].alusrca !== 2'b01 || trace[2].alusrcb !== 2'b10 ||
          trace[3].st !== 4'(P_ALUWB) || trace[3].regwrite !== 1'b1) begin
         errors++;
         $display("FAIL jal: pcwrite %b alusrca %b alusrcb %b next state %0d regwrite %b expected 1 01 10 8 1",
                  trace[2].pcwrite, trace[2].alusrca, trace[2].alusrcb, trace[3].st, trace[3].regwrite);
      end
   endtask

   task automatic test_illegal();
      logic [6:0] t_op[3] = '{7'b0000000, 7'b1111111, 7'b0110111};
      int pulses;
      for (int i = 0; i < 3; i++) begin
         run_instr("illegal", t_op[i], 3'd0, 1'b0, 2, -1);
         pulses = 0;
         foreach (trace[j]) pulses += int'(trace[j].illegal);
         #1;
         checks++;
         if (pulses != 1 || trace[2].illegal !== 1'b1 || state !== 4'(P_FETCH)) begin
            errors++;
            $display("FAIL illegal[%0d]: pulses %0d state after %0d expected 1 0", i, pulses, state);
         end
      end
   endtask

   task automatic test_reset_abort();
      run_instr("abort_sw", SW, 3'd2, 1'b0, 2, 3);
      #1;
      checks++;
      if (trace[3].memwrite !== 1'b0 || trace[3].st !== 4'(P_MEMWRITE) || state !== 4'(P_FETCH)) begin
         errors++;
         $display("FAIL abort_sw: memwrite %b state %0d after edge %0d expected 0 5 0",
                  trace[3].memwrite, trace[3].st, state);
      end
      run_instr("abort_lw", LW, 3'd2, 1'b0, 2, 4);
      #1;
      checks++;
      if (trace[4].regwrite !== 1'b0 || state !== 4'(P_FETCH)) begin
         errors++;
         $display("FAIL abort_lw: regwrite %b state after edge %0d expected 0 0", trace[4].regwrite, state);
      end
   endtask

   task automatic test_back_to_back();
      logic [6:0] ops[7] = '{LW, SW, RT, IT, BR, JL, 7'b0};
      logic [6:0] o;
      int sel;
      for (int n = 0; n < 40; n++) begin
         sel = int'($urandom_range(0, 6));
         o   = (sel == 6) ? 7'($urandom) : ops[sel];
         run_instr("random", o, 3'($urandom), 1'($urandom), 2, -1);
      end
   endtask

   initial begin
      test_reset();
      test_lw();
      test_sw();
      test_alu_decode();
      test_branch();
      test_jal();
      test_illegal();
      test_reset_abort();
      test_back_to_back();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
